// File: rtl/score_tracker_if.sv
// score_tracker_if: game handshake, pipe/bird X positions and the score display
// outputs of score_tracker. The master drives the game inputs; the slave (the
// tracker) drives the registered score and state outputs.
interface score_tracker_if #(
    parameter int W = 10
);
    logic         Start;
    logic         Stop;
    logic         Ack;
    logic [W-1:0] Bird_X_L;
    logic [W-1:0] Pipe_X_R0;
    logic [W-1:0] Pipe_X_R1;
    logic [W-1:0] Pipe_X_R2;
    logic [W-1:0] Pipe_X_R3;
    logic [15:0]  Score_BCD;
    logic [15:0]  High_BCD;
    logic         New_High;
    logic         Overflow;
    logic         q_Idle;
    logic         q_Play;
    logic         q_Drain;
    logic         q_Over;

    modport master (
        output Start, Stop, Ack, Bird_X_L,
        output Pipe_X_R0, Pipe_X_R1, Pipe_X_R2, Pipe_X_R3,
        input  Score_BCD, High_BCD, New_High, Overflow,
        input  q_Idle, q_Play, q_Drain, q_Over
    );

    modport slave (
        input  Start, Stop, Ack, Bird_X_L,
        input  Pipe_X_R0, Pipe_X_R1, Pipe_X_R2, Pipe_X_R3,
        output Score_BCD, High_BCD, New_High, Overflow,
        output q_Idle, q_Play, q_Drain, q_Over
    );
endinterface

// File: rtl/score_tracker.sv
// score_tracker: counts pipes cleared by the bird and keeps the running score
// and the session high score as 4-digit packed BCD.
// A pass is a pipe right edge moving from >= Bird_X_L to < Bird_X_L; passes are
// queued in a small saturating pending counter and drained into the BCD score
// at one increment per cycle. The score saturates at 9999 and flags Overflow.
// Optional build macro SCORE_BLANK_EN: leading zero digits of Score_BCD and
// High_BCD are shown as 4'hF (display blank); digit0 is never blanked.
module score_tracker #(
    parameter int W        = 10,
    parameter int PEND_MAX = 7
) (
    input  logic           Clk,
    input  logic           reset,
    score_tracker_if.slave bus
);
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_PLAY  = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_OVER  = 4'b1000
    } state_t;

    localparam logic [3:0] PEND_SAT = 4'(PEND_MAX);

    state_t      state, state_next;
    logic [W-1:0] bird_x;
    logic [W-1:0] pipe_x [4];
    logic [3:0]  passed, prev_passed, events;
    logic [2:0]  pending;
    logic [3:0]  pend_sum;
    logic [15:0] score_q, high_q;
    logic        new_high_q, overflow_q;
    logic        clear_game, count_en, inc_en, drain_done;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // One-step packed BCD increment with digit carry; caller guards 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef SCORE_BLANK_EN
    // Replace leading zero digits 3..1 with the blank code.
    function automatic logic [15:0] blank_lz(input logic [15:0] v);
        logic [15:0] r;
        logic        lead;
        r    = v;
        lead = 1'b1;
        for (int d = 3; d >= 1; d--) begin
            if (lead && (v[d*4 +: 4] == 4'd0)) begin
                r[d*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    assign bird_x    = bus.Bird_X_L;
    assign pipe_x[0] = bus.Pipe_X_R0;
    assign pipe_x[1] = bus.Pipe_X_R1;
    assign pipe_x[2] = bus.Pipe_X_R2;
    assign pipe_x[3] = bus.Pipe_X_R3;

    // Per-pipe "already behind the bird" compare; rising edges are pass events.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            passed[i] = (pipe_x[i] < bird_x);
        end
    end

    assign events = passed & ~prev_passed;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next; no latch.
        state_next = state;
        unique case (state)
            ST_IDLE:  if (bus.Start)       state_next = ST_PLAY;
            ST_PLAY:  if (bus.Stop)        state_next = ST_DRAIN;
            ST_DRAIN: if (pending == 3'd0) state_next = ST_OVER;
            ST_OVER:  if (bus.Ack)         state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // State decode: datapath strobes and one-hot state outputs.
    always_comb begin
        clear_game  = (state == ST_IDLE) && bus.Start;
        count_en    = (state == ST_PLAY);
        inc_en      = ((state == ST_PLAY) || (state == ST_DRAIN)) && (pending != 3'd0);
        drain_done  = (state == ST_DRAIN) && (pending == 3'd0);
        bus.q_Idle  = (state == ST_IDLE);
        bus.q_Play  = (state == ST_PLAY);
        bus.q_Drain = (state == ST_DRAIN);
        bus.q_Over  = (state == ST_OVER);
    end

    // Pass history follows the inputs every cycle so re-entry never miscounts.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            prev_passed <= 4'b1111;
        end else begin
            prev_passed <= passed;
        end
    end

    // Pending sum: new events (PLAY only) minus the increment being applied.
    always_comb begin
        pend_sum = 4'(pending)
                 + (count_en ? 4'(popcount4(events)) : 4'd0)
                 - (inc_en ? 4'd1 : 4'd0);
    end

    // Saturating pending-increment counter.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            pending <= 3'd0;
        end else if (clear_game) begin
            pending <= 3'd0;
        end else if (pend_sum > PEND_SAT) begin
            pending <= PEND_SAT[2:0];
        end else begin
            pending <= pend_sum[2:0];
        end
    end

    // Running score: one BCD increment per cycle while pending, holds at 9999.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            score_q    <= 16'h0000;
            overflow_q <= 1'b0;
        end else if (clear_game) begin
            score_q    <= 16'h0000;
            overflow_q <= 1'b0;
        end else if (inc_en) begin
            if (score_q == 16'h9999) begin
                overflow_q <= 1'b1;
            end else begin
                score_q <= bcd_inc(score_q);
            end
        end
    end

    // Session high score, updated once the drain has emptied the pending count.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            high_q     <= 16'h0000;
            new_high_q <= 1'b0;
        end else if (clear_game) begin
            new_high_q <= 1'b0;
        end else if (drain_done && (score_q > high_q)) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
        end
    end

    assign bus.New_High = new_high_q;
    assign bus.Overflow = overflow_q;
`ifdef SCORE_BLANK_EN
    assign bus.Score_BCD = blank_lz(score_q);
    assign bus.High_BCD  = blank_lz(high_q);
`else
    assign bus.Score_BCD = score_q;
    assign bus.High_BCD  = high_q;
`endif
endmodule
